product_idx_write_sequencer: RTL and testbench
==============================================

// Module: product_idx_write_sequencer
// PURPOSE
// Sequences accumulator results from N_REQ producer lanes into the product register bank
// ([DIM_C][DIM_A][ACC_WIDTH]), one entry per cycle.
// Round-robin arbitration picks the lane; the block generates write enable, C/A indices and data.
// It also tracks bank fill. Sits between the LUT accumulators and the product register bank;
// signals the downstream consumer when the bank is full and waits for its release.
// PARAMETERS
// N_REQ      4            number of producer lanes (>=1)
// DIM_A      `DIM_A       entries per C row (>=1)
// DIM_C      `DIM_C       C rows (>=1)
// ACC_WIDTH  `ACC_WIDTH   accumulator/data width
// A_W        $clog2(DIM_A) (min 1) A index width; C_W likewise for DIM_C
// PORTS
// clk          in   1                 clock, rising edge
// rst          in   1                 synchronous reset, active-high
// start        in   1                 pulse: begin filling bank from entry (0,0)
// abort        in   1                 pulse: discard fill in progress, return to IDLE
// req_valid    in   N_REQ             per-lane result valid
// req_data     in   N_REQ*ACC_WIDTH   per-lane result, lane i at [i*ACC_WIDTH +: ACC_WIDTH]
// req_ready    out  N_REQ             one-hot grant; handshake = valid & ready
// wr_en        out  1                 bank write enable
// wr_c_idx     out  C_W               bank C index
// wr_a_idx     out  A_W               bank A index
// wr_data      out  ACC_WIDTH         bank write data
// busy         out  1                 high in FILL
// full         out  1                 high in FULL (all DIM_C*DIM_A entries written)
// drain_ack    in   1                 consumer has read bank; release FULL
// BEHAVIOUR
// - Reset (rst=1 at posedge): state=IDLE, wr_en=0, wr_c_idx=0, wr_a_idx=0, wr_data=0, busy=0,
//   full=0, rr pointer=0; req_ready=0.
// - States: IDLE -start-> FILL; FILL -last handshake-> FULL; FULL -drain_ack-> IDLE.
//   abort in FILL or FULL -> IDLE; abort has priority over all other inputs.
//   start in FILL is ignored.
// - FULL with drain_ack=1 and start=1 in the same cycle -> FILL directly; counters cleared.
// - Arbitration (FILL only, combinational): req_ready = one-hot of the first valid lane
//   scanning from rr pointer upward, wrapping mod N_REQ.
//   At most one handshake per cycle. On handshake, rr pointer <= granted lane + 1 (mod N_REQ).
//   req_ready=0 outside FILL and in the cycle abort=1.
// - Write latency 1: a handshake in cycle t gives, in cycle t+1,
//   wr_en=1, wr_data=granted lane data, and wr_c_idx/wr_a_idx = fill counter value at t.
//   wr_en=0 in every other cycle. Indices/data hold their last value when wr_en=0.
// - Fill counter: A advances first: a=DIM_A-1 wraps to 0 and c increments.
//   The handshake at (c=DIM_C-1, a=DIM_A-1) is the last: state -> FULL next cycle,
//   the same cycle as the final wr_en. Counter clears to (0,0) on entering FILL.
// - abort in the same cycle as a handshake: the handshake is suppressed (req_ready=0),
//   so no write is issued. A write already registered from the previous cycle still
//   completes (wr_en=1 for that one cycle).
// - busy = (state==FILL); full = (state==FULL); both registered.
// - Data passes through unmodified, no arithmetic. Lanes not granted keep their data;
//   valid may drop without handshake.
// CONFIGURATION
// PRODUCT_SEQ_PERF_EN defined: adds outputs
//   stall_cnt [31:0]: cycles in FILL with req_valid==0; saturates at 32'hFFFF_FFFF.
//   fill_cnt  [15:0]: completed FILL->FULL transitions; wraps.
//   Both are cleared by rst only. abort and start do not clear them.
// PRODUCT_SEQ_PERF_EN undefined: these ports and their counters do not exist;
//   all other behaviour is identical.
// TESTING
// 1 Reset mid-FILL after 3 writes -> next cycle all outputs at reset values, state IDLE;
//   start -> first write at (0,0).
// 2 N_REQ=4, DIM_C=1, DIM_A=8, all lanes valid continuously, start ->
//   grants lane 0,1,2,3,0,1,2,3; wr_a_idx 0..7 on consecutive cycles, data matches lane;
//   full=1 same cycle as a=7 write.
// 3 Only lane 2 valid, 0xABCD -> req_ready=4'b0100 each cycle, 8 writes of 0xABCD;
//   lane 1 joins mid-way -> grants alternate 1,2.
// 4 DIM_C=2, DIM_A=3 -> index order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
//   then full=1, req_ready=0 despite valid until drain_ack.
// 5 abort coincident with a handshake at a=4 -> no write for it; previously granted a=3
//   write still seen; IDLE next cycle.
//   FULL with start=1 and drain_ack=1 together -> FILL, counter at (0,0).
// 6 PRODUCT_SEQ_PERF_EN: 5 idle FILL cycles -> stall_cnt=5; two complete fills -> fill_cnt=2.

Source files
------------

// File: rtl/product_idx_write_sequencer.sv
// Round-robin sequencer that writes producer-lane results into the product register bank.
// Optional performance counters (stall_cnt, fill_cnt) are enabled by defining PRODUCT_SEQ_PERF_EN.
`ifndef DIM_A
`define DIM_A 8
`endif
`ifndef DIM_C
`define DIM_C 4
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif

module product_idx_write_sequencer #(
  parameter int N_REQ     = 4,
  parameter int DIM_A     = `DIM_A,
  parameter int DIM_C     = `DIM_C,
  parameter int ACC_WIDTH = `ACC_WIDTH,
  parameter int A_W       = (DIM_A > 1) ? $clog2(DIM_A) : 1,
  parameter int C_W       = (DIM_C > 1) ? $clog2(DIM_C) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*ACC_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       wr_en,
  output logic [C_W-1:0]             wr_c_idx,
  output logic [A_W-1:0]             wr_a_idx,
  output logic [ACC_WIDTH-1:0]       wr_data,
  output logic                       busy,
  output logic                       full,
  input  logic                       drain_ack
`ifdef PRODUCT_SEQ_PERF_EN
  ,
  output logic [31:0]                stall_cnt,
  output logic [15:0]                fill_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [C_W-1:0]       c_reg;
  logic [A_W-1:0]       a_reg;
  logic                 wr_en_reg;
  logic [C_W-1:0]       wr_c_reg;
  logic [A_W-1:0]       wr_a_reg;
  logic [ACC_WIDTH-1:0] wr_data_reg;
  logic                 busy_reg, full_reg;

  logic                 found;
  logic [PTR_W-1:0]     grant_idx;
  int                   lane;
  logic                 hs;
  logic                 last_entry;
  logic                 enter_fill;

  // Scan lanes starting at the round-robin pointer, wrapping mod N_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    lane      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      lane = int'(rr_ptr_reg) + k;
      if (lane >= N_REQ) lane = lane - N_REQ;
      if (!found && req_valid[lane[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = lane[PTR_W-1:0];
      end
    end
  end

  assign hs         = (state_reg == S_FILL) && !abort && found;
  assign last_entry = (c_reg == C_W'(DIM_C - 1)) && (a_reg == A_W'(DIM_A - 1));

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign req_ready[gi] = hs && (grant_idx == PTR_W'(gi));
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start && !abort) state_next = S_FILL;
      S_FILL: begin
        if (abort)                 state_next = S_IDLE;
        else if (hs && last_entry) state_next = S_FULL;
      end
      S_FULL: begin
        if (abort)                  state_next = S_IDLE;
        else if (drain_ack && start) state_next = S_FILL;
        else if (drain_ack)          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FULL->FILL with drain_ack+start also counts as entering a fresh fill.
  assign enter_fill = (state_next == S_FILL) && (state_reg != S_FILL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      rr_ptr_reg <= '0;
      c_reg      <= '0;
      a_reg      <= '0;
      busy_reg   <= 1'b0;
      full_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == S_FILL);
      full_reg  <= (state_next == S_FULL);
      if (hs)
        rr_ptr_reg <= (grant_idx == PTR_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (enter_fill) begin
        c_reg <= '0;
        a_reg <= '0;
      end else if (hs) begin
        if (a_reg == A_W'(DIM_A - 1)) begin
          a_reg <= '0;
          c_reg <= last_entry ? '0 : c_reg + 1'b1;
        end else begin
          a_reg <= a_reg + 1'b1;
        end
      end
    end
  end

  // Write port: one cycle behind the handshake; indices and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_reg   <= 1'b0;
      wr_c_reg    <= '0;
      wr_a_reg    <= '0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= hs;
      if (hs) begin
        wr_c_reg    <= c_reg;
        wr_a_reg    <= a_reg;
        wr_data_reg <= req_data[grant_idx*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  assign wr_en    = wr_en_reg;
  assign wr_c_idx = wr_c_reg;
  assign wr_a_idx = wr_a_reg;
  assign wr_data  = wr_data_reg;
  assign busy     = busy_reg;
  assign full     = full_reg;

`ifdef PRODUCT_SEQ_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [15:0] fill_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      fill_cnt_reg  <= '0;
    end else begin
      if ((state_reg == S_FILL) && (req_valid == '0) && (stall_cnt_reg != 32'hFFFF_FFFF))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if ((state_reg == S_FILL) && (state_next == S_FULL))
        fill_cnt_reg <= fill_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign fill_cnt  = fill_cnt_reg;
`endif

endmodule

// File: tb/tb_product_idx_write_sequencer.sv
// Directed bench for product_idx_write_sequencer: one 1x8 bank and one 2x3 bank share stimulus.
module tb_product_idx_write_sequencer;
  localparam int N = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst, start, abort, drain_ack;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;

  logic [N-1:0] r8;  logic we8;  logic [0:0] c8;  logic [2:0] a8;  logic [W-1:0] d8;  logic busy8, full8;
  logic [N-1:0] r23; logic we23; logic [0:0] c23; logic [1:0] a23; logic [W-1:0] d23; logic busy23, full23;
`ifdef PRODUCT_SEQ_PERF_EN
  logic [31:0] st8, st23;
  logic [15:0] fc8, fc23;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  product_idx_write_sequencer #(.N_REQ(N), .DIM_A(8), .DIM_C(1), .ACC_WIDTH(W)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .req_valid(req_valid), .req_data(req_data), .req_ready(r8),
    .wr_en(we8), .wr_c_idx(c8), .wr_a_idx(a8), .wr_data(d8),
    .busy(busy8), .full(full8), .drain_ack(drain_ack)
`ifdef PRODUCT_SEQ_PERF_EN
    , .stall_cnt(st8), .fill_cnt(fc8)
`endif
  );

  product_idx_write_sequencer #(.N_REQ(N), .DIM_A(3), .DIM_C(2), .ACC_WIDTH(W)) u_d23 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .req_valid(req_valid), .req_data(req_data), .req_ready(r23),
    .wr_en(we23), .wr_c_idx(c23), .wr_a_idx(a23), .wr_data(d23),
    .busy(busy23), .full(full23), .drain_ack(drain_ack)
`ifdef PRODUCT_SEQ_PERF_EN
    , .stall_cnt(st23), .fill_cnt(fc23)
`endif
  );

  function automatic logic [W-1:0] lv(int i);
    return 16'hA0A0 + 16'h1111 * i[15:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; drain_ack = 1'b0; req_valid = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = lv(i);
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic begin_fill(input logic [N-1:0] v);
    req_valid = v;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req_valid = 4'hF;
    #1;
    checks++; if (r8 !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", r8); end
    checks++; if (we8 !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", we8); end
    checks++; if ({c8, a8} !== 4'h0) begin errors++; $display("FAIL reset_idx: got c=%0d a=%0d expected 0,0", c8, a8); end
    checks++; if (d8 !== 16'h0) begin errors++; $display("FAIL reset_data: got %h expected 0000", d8); end
    checks++; if ({busy8, full8, busy23, full23} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy8, full8, busy23, full23}); end
  endtask

  task automatic test_reset_mid_fill();
    do_reset();
    begin_fill(4'hF);
    for (int k = 0; k < 3; k++) cyc();
    checks++; if (we8 !== 1'b1 || a8 !== 3'd2) begin errors++; $display("FAIL midfill_third_write: got we=%b a=%0d expected 1,2", we8, a8); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++; if ({we8, c8, a8, d8, busy8, full8} !== 23'h0) begin errors++; $display("FAIL midfill_reset_outputs: got we=%b c=%0d a=%0d d=%h busy=%b full=%b expected all 0", we8, c8, a8, d8, busy8, full8); end
    checks++; if (r8 !== 4'b0000) begin errors++; $display("FAIL midfill_reset_ready: got %b expected 0000", r8); end
    begin_fill(4'hF);
    checks++; if (busy8 !== 1'b1 || r8 !== 4'b0001) begin errors++; $display("FAIL midfill_restart_grant: got busy=%b ready=%b expected 1,0001", busy8, r8); end
    cyc();
    $display("write c=%0d a=%0d data=%h", c8, a8, d8);
    checks++; if (we8 !== 1'b1 || c8 !== 1'b0 || a8 !== 3'd0 || d8 !== lv(0)) begin errors++; $display("FAIL midfill_first_write: got we=%b c=%0d a=%0d d=%h expected 1,0,0,%h", we8, c8, a8, d8, lv(0)); end
  endtask

  task automatic test_round_robin();
    do_reset();
    begin_fill(4'hF);
    for (int k = 0; k < 8; k++) begin
      checks++; if (r8 !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_grant k=%0d: got %b expected %b", k, r8, 4'(1 << (k % 4))); end
      cyc();
      $display("write c=%0d a=%0d data=%h full=%b", c8, a8, d8, full8);
      checks++; if (we8 !== 1'b1 || c8 !== 1'b0 || a8 !== 3'(k) || d8 !== lv(k % 4)) begin errors++; $display("FAIL rr_write k=%0d: got we=%b c=%0d a=%0d d=%h expected 1,0,%0d,%h", k, we8, c8, a8, d8, k, lv(k % 4)); end
      checks++; if (full8 !== (k == 7)) begin errors++; $display("FAIL rr_full k=%0d: got %b expected %b", k, full8, (k == 7)); end
    end
    checks++; if (r8 !== 4'b0000 || busy8 !== 1'b0) begin errors++; $display("FAIL rr_full_no_grant: got ready=%b busy=%b expected 0000,0", r8, busy8); end
  endtask

  task automatic test_single_lane();
    int g [8] = '{2, 2, 2, 2, 1, 2, 1, 2};
    do_reset();
    req_data[2*W +: W] = 16'hABCD;
    begin_fill(4'b0100);
    for (int k = 0; k < 8; k++) begin
      if (k == 4) req_valid = 4'b0110;
      #1;
      checks++; if (r8 !== 4'(1 << g[k])) begin errors++; $display("FAIL lane_grant k=%0d: got %b expected %b", k, r8, 4'(1 << g[k])); end
      cyc();
      $display("write a=%0d data=%h", a8, d8);
      checks++; if (we8 !== 1'b1 || a8 !== 3'(k) || d8 !== ((g[k] == 2) ? 16'hABCD : lv(1))) begin errors++; $display("FAIL lane_write k=%0d: got we=%b a=%0d d=%h expected 1,%0d,%h", k, we8, a8, d8, k, ((g[k] == 2) ? 16'hABCD : lv(1))); end
    end
  endtask

  task automatic test_two_rows();
    do_reset();
    begin_fill(4'hF);
    for (int k = 0; k < 6; k++) begin
      checks++; if (r23 !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rows_grant k=%0d: got %b expected %b", k, r23, 4'(1 << (k % 4))); end
      cyc();
      $display("write c=%0d a=%0d data=%h", c23, a23, d23);
      checks++; if (we23 !== 1'b1 || c23 !== 1'(k / 3) || a23 !== 2'(k % 3) || d23 !== lv(k % 4)) begin errors++; $display("FAIL rows_write k=%0d: got we=%b c=%0d a=%0d d=%h expected 1,%0d,%0d,%h", k, we23, c23, a23, d23, k / 3, k % 3, lv(k % 4)); end
      checks++; if (full23 !== (k == 5)) begin errors++; $display("FAIL rows_full k=%0d: got %b expected %b", k, full23, (k == 5)); end
    end
    for (int j = 0; j < 3; j++) begin
      cyc();
      checks++; if (full23 !== 1'b1 || we23 !== 1'b0 || r23 !== 4'b0000) begin errors++; $display("FAIL rows_hold j=%0d: got full=%b we=%b ready=%b expected 1,0,0000", j, full23, we23, r23); end
    end
    drain_ack = 1'b1;
    cyc();
    drain_ack = 1'b0;
    checks++; if (full23 !== 1'b0 || busy23 !== 1'b0) begin errors++; $display("FAIL rows_drain: got full=%b busy=%b expected 0,0", full23, busy23); end
  endtask

  task automatic test_abort();
    do_reset();
    begin_fill(4'hF);
    for (int k = 0; k < 4; k++) cyc();
    abort = 1'b1;
    #1;
    checks++; if (r8 !== 4'b0000) begin errors++; $display("FAIL abort_ready: got %b expected 0000", r8); end
    checks++; if (we8 !== 1'b1 || a8 !== 3'd3 || d8 !== lv(3)) begin errors++; $display("FAIL abort_prior_write: got we=%b a=%0d d=%h expected 1,3,%h", we8, a8, d8, lv(3)); end
    cyc();
    abort = 1'b0;
    #1;
    checks++; if (we8 !== 1'b0 || a8 !== 3'd3 || d8 !== lv(3)) begin errors++; $display("FAIL abort_no_write: got we=%b a=%0d d=%h expected 0,3,%h", we8, a8, d8, lv(3)); end
    checks++; if (busy8 !== 1'b0 || full8 !== 1'b0 || r8 !== 4'b0000) begin errors++; $display("FAIL abort_idle: got busy=%b full=%b ready=%b expected 0,0,0000", busy8, full8, r8); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    begin_fill(4'hF);
    for (int k = 0; k < 6; k++) cyc();
    checks++; if (full23 !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b expected 1", full23); end
    start = 1'b1;
    drain_ack = 1'b1;
    cyc();
    start = 1'b0;
    drain_ack = 1'b0;
    #1;
    checks++; if (busy23 !== 1'b1 || full23 !== 1'b0 || r23 !== 4'b0100) begin errors++; $display("FAIL b2b_refill: got busy=%b full=%b ready=%b expected 1,0,0100", busy23, full23, r23); end
    cyc();
    $display("write c=%0d a=%0d data=%h", c23, a23, d23);
    checks++; if (we23 !== 1'b1 || c23 !== 1'b0 || a23 !== 2'd0 || d23 !== lv(2)) begin errors++; $display("FAIL b2b_first_write: got we=%b c=%0d a=%0d d=%h expected 1,0,0,%h", we23, c23, a23, d23, lv(2)); end
  endtask

`ifdef PRODUCT_SEQ_PERF_EN
  task automatic test_perf();
    do_reset();
    begin_fill(4'h0);
    for (int k = 0; k < 5; k++) cyc();
    checks++; if (st8 !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", st8); end
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) cyc();
    checks++; if (fc8 !== 16'd1 || full8 !== 1'b1) begin errors++; $display("FAIL perf_fill1: got fill=%0d full=%b expected 1,1", fc8, full8); end
    start = 1'b1;
    drain_ack = 1'b1;
    cyc();
    start = 1'b0;
    drain_ack = 1'b0;
    for (int k = 0; k < 8; k++) cyc();
    checks++; if (fc8 !== 16'd2 || st8 !== 32'd5) begin errors++; $display("FAIL perf_fill2: got fill=%0d stall=%0d expected 2,5", fc8, st8); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; drain_ack = 1'b0;
    req_valid = '0; req_data = '0;
    test_reset();
    test_reset_mid_fill();
    test_round_robin();
    test_single_lane();
    test_two_rows();
    test_abort();
    test_back_to_back();
`ifdef PRODUCT_SEQ_PERF_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
